boot_loader: RTL and testbench

- Upstream feeder of the data-memory bootloader path.
- Consumes bytes from the UART receiver and assembles them little-endian into 32-bit words.
- Drives the memory's debug, data_cpu and waddr_cpu inputs so that program/data images are written to consecutive word addresses before the core runs.
- Releases debug when the image is complete, or when an inter-byte timeout aborts the load.

---
 rtl/boot_loader.sv | 159 +++++++++++++++
 tb/tb_boot_loader.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/boot_loader.sv
`timescale 1ns/1ps
// Byte-stream bootloader: takes a little-endian 16-bit word count and then 4*N payload bytes
// from the UART receiver, and writes each assembled word to the next word address of data memory.
module boot_loader #(
    parameter int ADDR_W         = 13,
    parameter int MAX_WORDS      = 8192,
    parameter int TIMEOUT_CYCLES = 50000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_rdy,
    output logic        clr_rdy,
    output logic        debug,
    output logic [31:0] data_cpu,
    output logic [31:0] waddr_cpu,
    output logic        wr_stb,
    output logic        boot_done,
    output logic        boot_err
);

    localparam int CNT_W = ADDR_W + 1;
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_WORDS);

    localparam logic [2:0] S_LEN0    = 3'd0;
    localparam logic [2:0] S_LEN1    = 3'd1;
    localparam logic [2:0] S_PAYLOAD = 3'd2;
    localparam logic [2:0] S_LAST    = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;
    localparam logic [2:0] S_ERR     = 3'd5;

    logic [2:0]        state_q, state_d;
    logic [7:0]        n_lo_q, n_lo_d;
    logic [CNT_W-1:0]  neff_q, neff_d;
    logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [23:0]       asm_q, asm_d;
    logic [31:0]       data_q, data_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic              wr_stb_q, wr_stb_d;
    logic              clr_q;
    logic [TMO_W-1:0]  tmo_q, tmo_d;

    logic        receiving;
    logic        timing;
    logic        accept;
    logic        tmo_exp;
    logic [15:0] n_full;

    // Handshake: a byte is taken when rx_rdy is high in a receiving state and the
    // previous cycle did not already ack; the receiver drops rx_rdy one cycle after clr_rdy.
    assign receiving = (state_q == S_LEN0) || (state_q == S_LEN1) || (state_q == S_PAYLOAD);
    assign timing    = (state_q == S_LEN1) || (state_q == S_PAYLOAD);
    assign accept    = rx_rdy && receiving && !clr_q;
    assign tmo_exp   = timing && (tmo_q == TMO_LAST);
    assign n_full    = {rx_data, n_lo_q};

    assign clr_rdy   = accept;
    assign debug     = !((state_q == S_DONE) || (state_q == S_ERR));
    assign boot_done = (state_q == S_DONE);
    assign boot_err  = (state_q == S_ERR);
    assign data_cpu  = data_q;
    assign waddr_cpu = 32'(waddr_q);
    assign wr_stb    = wr_stb_q;

    always_comb begin
        state_d    = state_q;
        n_lo_d     = n_lo_q;
        neff_d     = neff_q;
        word_cnt_d = word_cnt_q;
        byte_idx_d = byte_idx_q;
        asm_d      = asm_q;
        data_d     = data_q;
        waddr_d    = waddr_q;
        wr_stb_d   = 1'b0;
        tmo_d      = '0;

        if (timing && !accept && !tmo_exp) begin
            tmo_d = tmo_q + TMO_W'(1);
        end

        case (state_q)
            S_LEN0: begin
                if (accept) begin
                    n_lo_d  = rx_data;
                    state_d = S_LEN1;
                end
            end
            S_LEN1: begin
                if (accept) begin
                    if (32'(n_full) > 32'(MAX_WORDS)) begin
                        neff_d = MAX_CNT;
                    end else begin
                        neff_d = CNT_W'(n_full);
                    end
                    state_d = (n_full == 16'd0) ? S_DONE : S_PAYLOAD;
                end else if (tmo_exp) begin
                    state_d = S_ERR;
                end
            end
            S_PAYLOAD: begin
                if (accept) begin
                    byte_idx_d = byte_idx_q + 2'd1;
                    case (byte_idx_q)
                        2'd0: asm_d[7:0]   = rx_data;
                        2'd1: asm_d[15:8]  = rx_data;
                        2'd2: asm_d[23:16] = rx_data;
                        default: begin
                            // Data and address load on the same edge so the pair is never mixed.
                            data_d     = {rx_data, asm_q};
                            waddr_d    = ADDR_W'(word_cnt_q);
                            wr_stb_d   = 1'b1;
                            word_cnt_d = word_cnt_q + CNT_W'(1);
                            if (word_cnt_d == neff_q) begin
                                state_d = S_LAST;
                            end
                        end
                    endcase
                end else if (tmo_exp) begin
                    state_d = S_ERR;
                end
            end
            // Keeps debug high through the final write strobe.
            S_LAST:  state_d = S_DONE;
            default: state_d = state_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_LEN0;
            n_lo_q     <= '0;
            neff_q     <= '0;
            word_cnt_q <= '0;
            byte_idx_q <= '0;
            asm_q      <= '0;
            data_q     <= '0;
            waddr_q    <= '0;
            wr_stb_q   <= 1'b0;
            clr_q      <= 1'b0;
            tmo_q      <= '0;
        end else begin
            state_q    <= state_d;
            n_lo_q     <= n_lo_d;
            neff_q     <= neff_d;
            word_cnt_q <= word_cnt_d;
            byte_idx_q <= byte_idx_d;
            asm_q      <= asm_d;
            data_q     <= data_d;
            waddr_q    <= waddr_d;
            wr_stb_q   <= wr_stb_d;
            clr_q      <= accept;
            tmo_q      <= tmo_d;
        end
    end

endmodule

// File: tb/tb_boot_loader.sv
`timescale 1ns/1ps
// Directed bench for boot_loader: frames, zero-length image, timeout abort,
// back-to-back rx_rdy, mid-load reset and an image larger than MAX_WORDS.
module tb_boot_loader;
    localparam int ADDR_W    = 2;
    localparam int MAX_WORDS = 4;
    localparam int TMO       = 100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_rdy = 1'b0;
    logic        clr_rdy, debug, wr_stb, boot_done, boot_err;
    logic [31:0] data_cpu, waddr_cpu;

    int total = 0;
    int bad = 0;
    int n_ack = 0;
    int n_b2b = 0;
    int n_stb_nodbg = 0;
    logic prev_clr = 1'b0;
    logic [63:0] got_q[$];
    logic [63:0] exp_q[$];

    boot_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_rdy(rx_rdy), .clr_rdy(clr_rdy),
        .debug(debug), .data_cpu(data_cpu), .waddr_cpu(waddr_cpu), .wr_stb(wr_stb),
        .boot_done(boot_done), .boot_err(boot_err)
    );

    always #5 clk = ~clk;

    // Monitor on the falling edge: ack counting, ack spacing and the write log.
    always @(negedge clk) begin
        if (clr_rdy) n_ack++;
        if (clr_rdy && prev_clr) n_b2b++;
        prev_clr = clr_rdy;
        if (wr_stb) begin
            got_q.push_back({waddr_cpu, data_cpu});
            if (!debug) n_stb_nodbg++;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_log(input string tag, input int base);
        int n;
        n = got_q.size() - base;
        check({tag, "_writes"}, 64'(n), 64'(exp_q.size()));
        for (int i = 0; i < n && i < exp_q.size(); i++) begin
            check({tag, "_write"}, got_q[base + i], exp_q[i]);
        end
        exp_q.delete();
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rx_rdy = 1'b0;
        wait_cycles(2);
        rst = 1'b0;
    endtask

    // Presents one byte until acked or 20 cycles elapse; returns at posedge+1.
    task automatic send_byte(input logic [7:0] b, output bit acked);
        acked = 1'b0;
        rx_data = b;
        rx_rdy = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (clr_rdy) acked = 1'b1;
            @(posedge clk);
            #1;
            if (acked) break;
        end
        rx_rdy = 1'b0;
    endtask

    task automatic send_list(input string tag, input logic [7:0] bytes[$]);
        bit ok;
        foreach (bytes[i]) begin
            send_byte(bytes[i], ok);
            check({tag, "_ack"}, 64'(ok), 64'd1);
        end
    endtask

    initial begin
        int base, a0, idx;
        bit ok;
        logic [7:0] b4[$];
        logic [7:0] b6[$];

        // Reset values
        wait_cycles(3);
        check("rst_debug", 64'(debug), 64'd1);
        check("rst_data", 64'(data_cpu), 64'd0);
        check("rst_addr", 64'(waddr_cpu), 64'd0);
        check("rst_strobes", {62'd0, clr_rdy, wr_stb}, 64'd0);
        check("rst_flags", {62'd0, boot_done, boot_err}, 64'd0);
        do_reset();

        // 1: two-word image
        base = got_q.size();
        a0 = n_ack;
        send_list("t1", '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE});
        wait_cycles(3);
        exp_q.push_back({32'd0, 32'h12345678});
        exp_q.push_back({32'd1, 32'hDEADBEEF});
        check_log("t1", base);
        check("t1_acks", 64'(n_ack - a0), 64'd10);
        check("t1_done", {62'd0, boot_done, debug}, 64'b10);
        check("t1_err", 64'(boot_err), 64'd0);
        check("t1_stb_dbg", 64'(n_stb_nodbg), 64'd0);

        // 2: zero-length image, trailing bytes ignored
        do_reset();
        base = got_q.size();
        send_list("t2", '{8'h00, 8'h00});
        #1;
        check("t2_done", {62'd0, boot_done, debug}, 64'b10);
        a0 = n_ack;
        send_byte(8'h5A, ok);
        check("t2_extra_ack", 64'(n_ack - a0), 64'd0);
        check_log("t2", base);

        // 3: inter-byte timeout
        do_reset();
        base = got_q.size();
        send_list("t3", '{8'h01, 8'h00, 8'hAA, 8'hBB});
        wait_cycles(95);
        check("t3_err_early", {62'd0, boot_err, debug}, 64'b01);
        wait_cycles(10);
        check("t3_err", {62'd0, boot_err, debug}, 64'b10);
        check("t3_done", 64'(boot_done), 64'd0);
        check("t3_data", 64'(data_cpu), 64'd0);
        check("t3_addr", 64'(waddr_cpu), 64'd0);
        check_log("t3", base);

        // 4: rx_rdy held high continuously
        do_reset();
        base = got_q.size();
        a0 = n_ack;
        b4 = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        idx = 0;
        rx_data = b4[0];
        rx_rdy = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (clr_rdy) idx++;
            @(posedge clk);
            #1;
            if (idx < b4.size()) rx_data = b4[idx];
        end
        rx_rdy = 1'b0;
        check("t4_acks", 64'(n_ack - a0), 64'd6);
        check("t4_b2b", 64'(n_b2b), 64'd0);
        exp_q.push_back({32'd0, 32'h44332211});
        check_log("t4", base);
        check("t4_done", {62'd0, boot_done, debug}, 64'b10);

        // Asynchronous reset out of DONE, checked before any clock edge
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_flags", {61'd0, boot_done, boot_err, debug}, 64'b001);
        check("arst_data", 64'(data_cpu), 64'd0);
        wait_cycles(1);
        rst = 1'b0;

        // 5: reset mid-payload, then a clean frame
        base = got_q.size();
        send_list("t5a", '{8'h03, 8'h00, 8'hC1, 8'hC2});
        rst = 1'b1;
        #2;
        check("t5_rst_flags", {61'd0, boot_done, boot_err, debug}, 64'b001);
        wait_cycles(1);
        rst = 1'b0;
        send_list("t5b", '{8'h01, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00});
        wait_cycles(3);
        exp_q.push_back({32'd0, 32'h00000001});
        check_log("t5", base);
        check("t5_done", {62'd0, boot_done, debug}, 64'b10);

        // 6: N=0xFFFF clamps to MAX_WORDS
        do_reset();
        base = got_q.size();
        b6 = '{8'hFF, 8'hFF};
        for (int k = 0; k < 16; k++) b6.push_back(8'h10 + 8'(k));
        send_list("t6", b6);
        wait_cycles(3);
        a0 = n_ack;
        send_byte(8'h99, ok);
        check("t6_extra_ack", 64'(n_ack - a0), 64'd0);
        exp_q.push_back({32'd0, 32'h13121110});
        exp_q.push_back({32'd1, 32'h17161514});
        exp_q.push_back({32'd2, 32'h1B1A1918});
        exp_q.push_back({32'd3, 32'h1F1E1D1C});
        check_log("t6", base);
        check("t6_done", {62'd0, boot_done, debug}, 64'b10);
        check("stb_dbg_all", 64'(n_stb_nodbg), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
